mem_addr_router: RTL
====================

# mem_addr_router

Parametrised, registered 1-to-N router for the native valid/ready memory bus. It replaces cascaded combinational address muxes between the CPU memory port and the RAM, ROM, peripheral and AES slaves. It adds:
- table-driven N-way decode with fixed priority;
- a registered request stage that breaks the decode path;
- a defined error response for unmapped addresses;
- an optional timeout watchdog for slaves that never assert ready.

## Interface
Parameters:
- N_SLAVES, 7, number of downstream slaves; legal range 1..16.
- BASE_ADDRS, {32'h40000000,32'h38000000,32'h30000000,32'h28000000,32'h20000000,32'h10000000,32'h00000000}, flat N_SLAVES*32 vector; slave i base address is bits [32*i+:32].
- ADDR_MASKS, {32'hC0000000,32'hF8000000,32'hF8000000,32'hF8000000,32'hF8000000,32'hF0000000,32'hF0000000}, flat N_SLAVES*32 vector; decode mask for slave i.
- TIMEOUT_CYCLES, 255, maximum number of ACCESS cycles before abort; legal range 1..65535.
- ERR_RDATA, 32'hDEADBEEF, read data returned on any error.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- s_mem_valid  in  1  request from the CPU side.
- s_mem_ready  out  1  one-cycle completion pulse.
- s_mem_addr  in  32  request address.
- s_mem_wdata  in  32  write data.
- s_mem_wstrb  in  4  byte strobes; 0 means read.
- s_mem_rdata  out  32  read data, valid while s_mem_ready=1.
- m_mem_valid  out  N_SLAVES  one-hot request valid, one bit per slave.
- m_mem_ready  in  N_SLAVES  per-slave ready.
- m_mem_addr  out  32  registered address, shared by all slaves.
- m_mem_wdata  out  32  registered write data, shared.
- m_mem_wstrb  out  4  registered strobes, shared.
- m_mem_rdata  in  N_SLAVES*32  per-slave read data; slave i uses bits [32*i+:32].
- err_valid  out  1  one-cycle pulse accompanying an error completion.
- err_type  out  1  0 = decode miss, 1 = timeout; held until the next error.
- err_addr  out  32  address of the last error; held until the next error.

## Operation
Address decode:
- Slave i hits when (addr & ADDR_MASKS[i]) == (BASE_ADDRS[i] & ADDR_MASKS[i]).
- If several slaves hit, the lowest index wins.
- If none hit, the request is a decode miss.

FSM states: IDLE, ACCESS, RESP.
- IDLE, s_mem_valid=1: capture addr, wdata and wstrb into the m_mem_* registers. Capture sel (the winning index) and a miss flag. Clear the timer. Go to ACCESS on a hit, or to RESP on a miss.
- ACCESS: m_mem_valid[sel]=1; all other bits are 0. The timer increments every cycle.
  - If m_mem_ready[sel]=1, register m_mem_rdata[sel] into s_mem_rdata and go to RESP.
  - If the timer reaches TIMEOUT_CYCLES-1 with no ready, drop m_mem_valid, load ERR_RDATA and go to RESP as a timeout.
  - If ready arrives in the same cycle as the timeout, ready wins and there is no error.
- RESP: s_mem_ready=1 for exactly one cycle, then go to IDLE.
  - On a miss or timeout: s_mem_rdata=ERR_RDATA, err_valid=1, and err_type/err_addr are updated.
  - Writes complete with the same pulse, so an error never stalls the CPU.
- m_mem_ready bits of non-selected slaves are ignored in every state.
- s_mem_addr, s_mem_wdata and s_mem_wstrb are sampled only in IDLE. Changes during ACCESS have no effect.
- s_mem_valid seen in the first IDLE cycle after RESP starts a new transaction.

## Timing
- Reset values: state=IDLE, m_mem_valid=0, s_mem_ready=0, s_mem_rdata=0, m_mem_addr/wdata/wstrb=0, err_valid=0, err_type=0, err_addr=0, timer=0.
- Hit latency: valid sampled at cycle 0 → m_mem_valid at cycle 1 → slave ready at cycle k ≥ 1 → s_mem_ready at cycle k+1. Minimum is 2 cycles; the CPU-to-slave path is fully registered.
- Miss latency: valid at cycle 0 → s_mem_ready with err_valid at cycle 1.
- Timeout: m_mem_valid is high for exactly TIMEOUT_CYCLES cycles, and s_mem_ready follows on the next cycle.
- rst asserted mid-transaction: all outputs reach reset values on the next edge and the slave request is abandoned without a response. Slaves must tolerate valid dropping.
- Timer width is clog2(TIMEOUT_CYCLES+1) bits. It is stopped in IDLE and RESP and cannot wrap.

## Configuration
- ROUTER_TIMEOUT_EN defined: the timer and timeout path are present as described above.
- ROUTER_TIMEOUT_EN undefined: there is no timer. ACCESS waits indefinitely for ready, err_type is tied to 0, and TIMEOUT_CYCLES is ignored.

## Test plan
- Read 0x28000010, slave 3 ready 2 cycles after m_mem_valid with rdata 0x12345678 → m_mem_valid=7'b0001000, m_mem_addr=0x28000010, s_mem_ready at cycle 4 with rdata 0x12345678, err_valid=0.
- Write 0x00000004, wdata 0xA5A5A5A5, wstrb 4'hF, slave 0 ready same cycle → m_mem_wdata=0xA5A5A5A5, s_mem_ready at cycle 2.
- Write wstrb 4'h3 to 0x80000000 (no slave matches under the default tables) → no m_mem_valid bit; s_mem_ready at cycle 1; err_valid=1, err_type=0, err_addr=0x80000000.
- With ROUTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, read 0x40000000 with slave 6 never ready → m_mem_valid[6] high for 8 cycles; then s_mem_ready, rdata 0xDEADBEEF, err_type=1.
- With ROUTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, read 0x40000000 with slave 6 ready exactly in the 8th ACCESS cycle → normal completion, err_valid=0.
- Read 0x10000000 with rst pulsed in cycle 2 before slave 1 is ready → all outputs 0 the next cycle; a subsequent read of 0x10000000 completes normally.

Source files
------------

// File: rtl/mem_addr_router.sv
// mem_addr_router: registered 1-to-N router for the native valid/ready memory bus.
// Table-driven fixed-priority decode, one request register stage, a defined
// error response for unmapped addresses and an optional slave watchdog.
//
// Optional feature macro: ROUTER_TIMEOUT_EN
//   defined   -> ACCESS aborts after TIMEOUT_CYCLES cycles with a timeout error
//   undefined -> no timer; ACCESS waits for ready forever; err_type tied to 0
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_mem_valid/ready   CPU-side request / one-cycle completion pulse
//   s_mem_addr/wdata    CPU-side address and write data
//   s_mem_wstrb         byte strobes, 0 = read
//   s_mem_rdata         read data, valid while s_mem_ready=1
//   m_mem_valid         one-hot request valid, one bit per slave
//   m_mem_ready         per-slave ready (only the selected bit is used)
//   m_mem_addr/wdata/wstrb  registered request fields, shared by all slaves
//   m_mem_rdata         per-slave read data, slave i at [32*i+:32]
//   err_valid           pulse with an error completion
//   err_type/err_addr   last error kind (0 miss, 1 timeout) and address

module mem_addr_router #(
    parameter int N_SLAVES = 7,
    parameter logic [N_SLAVES*32-1:0] BASE_ADDRS = {
        32'h40000000, 32'h38000000, 32'h30000000, 32'h28000000,
        32'h20000000, 32'h10000000, 32'h00000000},
    parameter logic [N_SLAVES*32-1:0] ADDR_MASKS = {
        32'hC0000000, 32'hF8000000, 32'hF8000000, 32'hF8000000,
        32'hF8000000, 32'hF0000000, 32'hF0000000},
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_mem_valid,
    output logic                  s_mem_ready,
    input  logic [31:0]           s_mem_addr,
    input  logic [31:0]           s_mem_wdata,
    input  logic [3:0]            s_mem_wstrb,
    output logic [31:0]           s_mem_rdata,
    output logic [N_SLAVES-1:0]   m_mem_valid,
    input  logic [N_SLAVES-1:0]   m_mem_ready,
    output logic [31:0]           m_mem_addr,
    output logic [31:0]           m_mem_wdata,
    output logic [3:0]            m_mem_wstrb,
    input  logic [N_SLAVES*32-1:0] m_mem_rdata,
    output logic                  err_valid,
    output logic                  err_type,
    output logic [31:0]           err_addr
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]  sel;
    logic        miss;
    logic        hit_any;
    logic [3:0]  hit_idx;
    logic        acc_ready;
    logic [31:0] sel_rdata;
    logic        tmo;

`ifdef ROUTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer;
    logic          timed_out;
    logic          err_type_q;

    assign tmo      = (timer == TW'(TIMEOUT_CYCLES - 1));
    assign err_type = err_type_q;
`else
    assign tmo      = 1'b0;
    assign err_type = 1'b0;
`endif

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((s_mem_addr & ADDR_MASKS[32*i +: 32]) ==
                (BASE_ADDRS[32*i +: 32] & ADDR_MASKS[32*i +: 32])) begin
                hit_any = 1'b1;
                hit_idx = 4'(i);
            end
        end
    end

    always_comb begin
        acc_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel == 4'(i)) begin
                acc_ready = m_mem_ready[i];
                sel_rdata = m_mem_rdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        m_mem_valid = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            m_mem_valid[i] = (state == ACCESS) && (sel == 4'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (s_mem_valid) begin
                    state_nxt = hit_any ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (acc_ready || tmo) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign s_mem_ready = (state == RESP);

`ifdef ROUTER_TIMEOUT_EN
    assign err_valid = (state == RESP) && (miss || timed_out);
`else
    assign err_valid = (state == RESP) && miss;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            m_mem_addr  <= '0;
            m_mem_wdata <= '0;
            m_mem_wstrb <= '0;
            s_mem_rdata <= '0;
            sel         <= '0;
            miss        <= 1'b0;
            err_addr    <= '0;
`ifdef ROUTER_TIMEOUT_EN
            timer       <= '0;
            timed_out   <= 1'b0;
            err_type_q  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (s_mem_valid) begin
                        m_mem_addr  <= s_mem_addr;
                        m_mem_wdata <= s_mem_wdata;
                        m_mem_wstrb <= s_mem_wstrb;
                        sel         <= hit_idx;
                        miss        <= ~hit_any;
`ifdef ROUTER_TIMEOUT_EN
                        timer       <= '0;
                        timed_out   <= 1'b0;
`endif
                        // Error fields update on entry to RESP so they are
                        // visible together with err_valid.
                        if (!hit_any) begin
                            s_mem_rdata <= ERR_RDATA;
                            err_addr    <= s_mem_addr;
`ifdef ROUTER_TIMEOUT_EN
                            err_type_q  <= 1'b0;
`endif
                        end
                    end
                end
                ACCESS: begin
`ifdef ROUTER_TIMEOUT_EN
                    timer <= timer + 1'b1;
`endif
                    if (acc_ready) begin
                        s_mem_rdata <= sel_rdata;
                    end else if (tmo) begin
                        s_mem_rdata <= ERR_RDATA;
                        err_addr    <= m_mem_addr;
`ifdef ROUTER_TIMEOUT_EN
                        timed_out   <= 1'b1;
                        err_type_q  <= 1'b1;
`endif
                    end
                end
                RESP: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule
